// File: rtl/htif_pkg.sv
// Shared HTIF definitions used by the host endpoint and the on-chip bridge:
// opcodes, frame lengths, controller state encoding and a frame builder.
package htif_pkg;

  localparam logic [7:0] HTIF_OP_READ  = 8'h01;
  localparam logic [7:0] HTIF_OP_WRITE = 8'h02;

  localparam int unsigned HTIF_LEN_READ  = 5;
  localparam int unsigned HTIF_LEN_WRITE = 9;
  localparam int unsigned HTIF_LEN_RSP   = 4;

  localparam int unsigned HTIF_FRAME_W = 8 * HTIF_LEN_WRITE;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWait
  } htif_state_e;

  // Opcode lands in the low byte so a right-shifting serializer emits it first.
  function automatic logic [HTIF_FRAME_W-1:0] htif_frame(input logic        write,
                                                         input logic [31:0] addr,
                                                         input logic [31:0] data);
    return write ? {data, addr, HTIF_OP_WRITE} : {32'h0, addr, HTIF_OP_READ};
  endfunction

endpackage

// File: rtl/htif_host_if.sv
// Bundle of the host endpoint's command/response and byte-stream signals.
// slave: the htif_host endpoint view; master: the driver/bench view.
interface htif_host_if;

  logic        cmd_ready;
  logic        cmd_valid;
  logic        cmd_write;
  logic [31:0] cmd_address;
  logic [31:0] cmd_data;

  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_error;

  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;

  logic        in_ready;
  logic        in_valid;
  logic [7:0]  in_data;

  modport slave (
    output cmd_ready,
    input  cmd_valid, cmd_write, cmd_address, cmd_data,
    output rsp_valid, rsp_data, rsp_error,
    input  out_ready,
    output out_valid, out_data,
    output in_ready,
    input  in_valid, in_data
  );

  modport master (
    input  cmd_ready,
    output cmd_valid, cmd_write, cmd_address, cmd_data,
    input  rsp_valid, rsp_data, rsp_error,
    output out_ready,
    input  out_valid, out_data,
    input  in_ready,
    output in_valid, in_data
  );

endinterface

// File: rtl/htif_byte_ser.sv
// Loadable right-shifting byte serializer with a valid/ready byte output.
// Load only while idle (count zero); the low byte is presented first.
module htif_byte_ser #(
  parameter int unsigned  MaxBytes = 9,
  localparam int unsigned CntW     = $clog2(MaxBytes + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic [8*MaxBytes-1:0] load_data_i,
  input  logic [CntW-1:0]       load_count_i,
  output logic                  valid_o,
  output logic [7:0]            data_o,
  input  logic                  ready_i,
  output logic                  last_o
);

  logic [8*MaxBytes-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]       count_q, count_d;

  assign valid_o = (count_q != '0);
  assign data_o  = shreg_q[7:0];
  assign last_o  = (count_q == CntW'(1));

  // Next state: load a new frame, or drop the byte just accepted.
  always_comb begin
    shreg_d = shreg_q;
    count_d = count_q;
    if (load_i) begin
      shreg_d = load_data_i;
      count_d = load_count_i;
    end else if (valid_o && ready_i) begin
      shreg_d = shreg_q >> 8;
      count_d = count_q - 1'b1;
    end
  end

  // Synchronous active-low reset abandons any frame in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shreg_q <= '0;
      count_q <= '0;
    end else begin
      shreg_q <= shreg_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/htif_host.sv
// Host-side HTIF endpoint: serializes word read/write commands into the SoC
// rx byte stream and assembles read responses from the SoC tx byte stream.
// Optional read-response watchdog enabled by defining HTIF_HOST_TIMEOUT_EN.
module htif_host
  import htif_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic        clk,
  input logic        reset_n,
  htif_host_if.slave bus_io
);

  localparam int unsigned SerCntW = $clog2(HTIF_LEN_WRITE + 1);

  htif_state_e state_q, state_d;
  logic        is_write_q, is_write_d;
  logic [31:0] rx_shreg_q, rx_shreg_d;
  logic [1:0]  rx_cnt_q, rx_cnt_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_valid_q, rsp_valid_d;

  logic        cmd_fire;
  logic        ser_load;
  logic        ser_valid;
  logic        ser_last;
  logic [7:0]  ser_data;

`ifdef HTIF_HOST_TIMEOUT_EN
  localparam int unsigned TimerW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              rsp_error_q, rsp_error_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  assign bus_io.cmd_ready = reset_n && (state_q == StIdle);
  assign cmd_fire         = bus_io.cmd_valid && bus_io.cmd_ready;
  assign bus_io.out_valid = ser_valid;
  assign bus_io.out_data  = ser_data;
  // The SoC tx path is never stalled; bytes outside WAIT are dropped.
  assign bus_io.in_ready  = 1'b1;
  assign bus_io.rsp_valid = rsp_valid_q;
  assign bus_io.rsp_data  = rsp_data_q;
`ifdef HTIF_HOST_TIMEOUT_EN
  assign bus_io.rsp_error = rsp_error_q;
`else
  assign bus_io.rsp_error = 1'b0;
`endif

  htif_byte_ser #(
    .MaxBytes (HTIF_LEN_WRITE)
  ) u_ser (
    .clk_i        (clk),
    .rst_ni       (reset_n),
    .load_i       (ser_load),
    .load_data_i  (htif_frame(bus_io.cmd_write, bus_io.cmd_address, bus_io.cmd_data)),
    .load_count_i (bus_io.cmd_write ? SerCntW'(HTIF_LEN_WRITE) : SerCntW'(HTIF_LEN_READ)),
    .valid_o      (ser_valid),
    .data_o       (ser_data),
    .ready_i      (bus_io.out_ready),
    .last_o       (ser_last)
  );

  // FSM next state, response assembly and pulse generation.
  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    rx_shreg_d  = rx_shreg_q;
    rx_cnt_d    = rx_cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    ser_load    = 1'b0;
`ifdef HTIF_HOST_TIMEOUT_EN
    rsp_error_d = 1'b0;
    timer_d     = '0;
`endif
    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          ser_load   = 1'b1;
          is_write_d = bus_io.cmd_write;
          state_d    = StSend;
        end
      end
      StSend: begin
        if (ser_valid && bus_io.out_ready && ser_last) begin
          state_d  = is_write_q ? StIdle : StWait;
          rx_cnt_d = '0;
        end
      end
      StWait: begin
        if (bus_io.in_valid) begin
          // First byte ends up in [7:0] after four shifts from the top.
          rx_shreg_d = {bus_io.in_data, rx_shreg_q[31:8]};
          if (rx_cnt_q == 2'(HTIF_LEN_RSP - 1)) begin
            rsp_data_d  = rx_shreg_d;
            rsp_valid_d = 1'b1;
            rx_cnt_d    = '0;
            state_d     = StIdle;
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
`ifdef HTIF_HOST_TIMEOUT_EN
    // Timer idles at zero outside WAIT, so entry to WAIT starts it cleared.
    if (state_q == StWait && !bus_io.in_valid) begin
      if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
        rsp_valid_d = 1'b1;
        rsp_error_d = 1'b1;
        rx_cnt_d    = '0;
        state_d     = StIdle;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
`endif
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      is_write_q  <= 1'b0;
      rx_shreg_q  <= '0;
      rx_cnt_q    <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      rx_shreg_q  <= rx_shreg_d;
      rx_cnt_q    <= rx_cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

`ifdef HTIF_HOST_TIMEOUT_EN
  // Watchdog timer and error flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      timer_q     <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      rsp_error_q <= rsp_error_d;
    end
  end
`endif

endmodule
